// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU codes, step enumeration and opcode classifiers for control_unit
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {S_RESET, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT} state_t;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  function automatic logic is_rtype(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR};
  endfunction
  function automatic logic is_imm(input logic [4:0] op);
    return op inside {OP_ADDI, OP_ANDI, OP_ORI};
  endfunction
endpackage

// File: rtl/control_unit.sv
// control_unit: Moore step sequencer decoding datapath controls from the current step and latched opcode
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_enable,
  output logic        r_select,
  output logic        ba_out,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        z_low_out,
  output logic        c_out,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        con_in,
  output logic        inc_pc,
  output logic        read,
  output logic        write,
  output logic [4:0]  alu_op,
  output logic        run
);
  state_t state_q, state_d, fin;
  logic [4:0] opcode_q, opcode_d;
  logic arith, rtype, imm, ld, ldi, st, br, ldst, ir_unused;
  assign ir_unused = ^ir[26:0];
  assign rtype = is_rtype(opcode_q);
  assign imm   = is_imm(opcode_q);
  assign arith = rtype | imm;
  assign ld    = opcode_q == OP_LD;
  assign ldi   = opcode_q == OP_LDI;
  assign st    = opcode_q == OP_ST;
  assign br    = opcode_q == OP_BR;
  assign ldst  = ld | ldi | st;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RESET;
      opcode_q <= OP_LD;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end
  // stop is only honoured on the edge leaving an instruction's last step
  always_comb begin
    fin      = stop ? S_HALT : T0;
    state_d  = state_q;
    opcode_d = state_q == T2 ? ir[31:27] : opcode_q;
    case (state_q)
      S_RESET: state_d = T0;
      T0:      state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3: begin
        case (opcode_q)
          OP_HALT: state_d = S_HALT;
          OP_NOP:  state_d = fin;
          default: state_d = (arith | ldst | br) ? T4 : fin;
        endcase
      end
      T4:      state_d = T5;
      T5:      state_d = (ld | st | br) ? T6 : fin;
      T6:      state_d = br ? fin : T7;
      T7:      state_d = fin;
      default: state_d = state_q;
    endcase
  end
  always_comb begin
    {gra, grb, grc, r_enable, r_select, ba_out} = '0;
    {pc_out, mdr_out, z_low_out, c_out} = '0;
    {pc_in, ir_in, mar_in, mdr_in, y_in, z_in, con_in} = '0;
    {inc_pc, read, write} = '0;
    alu_op = '0;
    run = state_q != S_RESET && state_q != S_HALT;
    case (state_q)
      T0: {pc_out, mar_in, inc_pc, z_in} = '1;
      T1: {z_low_out, pc_in, read, mdr_in} = '1;
      T2: {mdr_out, ir_in} = '1;
      T3: begin
        grb      = arith | ldst;
        y_in     = arith | ldst;
        ba_out   = ldst;
        gra      = br;
        con_in   = br;
        r_select = arith | ldst | br;
      end
      T4: begin
        grc      = rtype;
        r_select = rtype;
        c_out    = imm | ldst;
        z_in     = arith | ldst;
        alu_op   = arith ? opcode_q : ldst ? ALU_ADD : 5'b0;
        pc_out   = br;
        y_in     = br;
      end
      T5: begin
        z_low_out = arith | ldst;
        gra       = arith | ldi;
        r_enable  = arith | ldi;
        mar_in    = ld | st;
        c_out     = br;
        z_in      = br;
        alu_op    = br ? ALU_ADD : 5'b0;
      end
      T6: begin
        read      = ld;
        mdr_in    = ld | st;
        gra       = st;
        r_select  = st;
        z_low_out = br;
        pc_in     = br & con_ff;
      end
      T7: begin
        mdr_out  = ld;
        gra      = ld;
        r_enable = ld;
        write    = st;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven per-cycle output checks plus reset/halt corner sequences
module tb_control_unit;
  logic clk = 0, reset = 1, stop = 0, con_ff = 0;
  logic [31:0] ir = '0;
  logic gra, grb, grc, r_enable, r_select, ba_out, pc_out, mdr_out, z_low_out, c_out;
  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, con_in, inc_pc, read, write, run;
  logic [4:0] alu_op;
  int checks = 0, fails = 0;
  logic win = 0, write_seen = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .stop(stop), .ir(ir), .con_ff(con_ff),
    .gra(gra), .grb(grb), .grc(grc), .r_enable(r_enable), .r_select(r_select), .ba_out(ba_out),
    .pc_out(pc_out), .mdr_out(mdr_out), .z_low_out(z_low_out), .c_out(c_out),
    .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in),
    .con_in(con_in), .inc_pc(inc_pc), .read(read), .write(write), .alu_op(alu_op), .run(run)
  );

  always #5 clk = ~clk;
  always @(posedge write) if (win) write_seen = 1;

  localparam logic [19:0] GRA  = 20'd1 << 19, GRB = 20'd1 << 18, GRC = 20'd1 << 17, REN = 20'd1 << 16;
  localparam logic [19:0] RSEL = 20'd1 << 15, BA  = 20'd1 << 14, PCO = 20'd1 << 13, MDRO = 20'd1 << 12;
  localparam logic [19:0] ZLO  = 20'd1 << 11, CO  = 20'd1 << 10, PCI = 20'd1 << 9,  IRI = 20'd1 << 8;
  localparam logic [19:0] MARI = 20'd1 << 7,  MDRI = 20'd1 << 6, YI  = 20'd1 << 5,  ZI  = 20'd1 << 4;
  localparam logic [19:0] CONI = 20'd1 << 3,  INC = 20'd1 << 2,  RD  = 20'd1 << 1,  WR  = 20'd1;
  localparam logic [19:0] F0 = PCO | MARI | INC | ZI, F1 = ZLO | PCI | RD | MDRI, F2 = MDRO | IRI;

  typedef struct {
    string       nm;
    logic [31:0] ir;
    logic        con, stp;
    logic [19:0] b;
    logic [4:0]  a;
    logic        r;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string nm, input logic [19:0] eb, input logic [4:0] ea, input logic er);
    logic [19:0] ab;
    ab = {gra, grb, grc, r_enable, r_select, ba_out, pc_out, mdr_out, z_low_out, c_out,
          pc_in, ir_in, mar_in, mdr_in, y_in, z_in, con_in, inc_pc, read, write};
    checks++;
    if (ab !== eb || alu_op !== ea || run !== er) begin
      fails++;
      $display("FAIL %s: got ctl=%05h alu=%0d run=%b, want ctl=%05h alu=%0d run=%b", nm, ab, alu_op, run, eb, ea, er);
    end
  endtask

  task automatic step(input string nm, input logic [31:0] i, input logic c, input logic s,
                      input logic [19:0] eb, input logic [4:0] ea, input logic er);
    @(negedge clk);
    ir = i; con_ff = c; stop = s;
    #1 check(nm, eb, ea, er);
  endtask

  task automatic push(input string nm, input logic [31:0] i, input logic c, input logic s,
                      input logic [19:0] b, input logic [4:0] a, input logic r);
    vq.push_back('{nm, i, c, s, b, a, r});
  endtask

  task automatic fetch(input string nm, input logic [31:0] i, input logic c);
    push({nm, "_t0"}, i, c, 0, F0, 0, 1);
    push({nm, "_t1"}, i, c, 0, F1, 0, 1);
    push({nm, "_t2"}, i, c, 0, F2, 0, 1);
  endtask

  task automatic pulse_reset(input string nm);
    #2 reset = 1;
    #1 check({nm, "_async"}, 0, 0, 0);
    @(posedge clk);
    #1 check({nm, "_held"}, 0, 0, 0);
    @(negedge clk) reset = 0;
  endtask

  initial begin
    fetch("add", 32'h18918000, 0);
    push("add_t3", 32'h18918000, 0, 0, GRB | RSEL | YI, 0, 1);
    push("add_t4", 32'h18918000, 0, 0, GRC | RSEL | ZI, 3, 1);
    push("add_t5", 32'h18918000, 0, 0, ZLO | GRA | REN, 0, 1);
    fetch("ld", 32'h00800000, 0);
    push("ld_t3", 32'h00800000, 0, 0, GRB | RSEL | BA | YI, 0, 1);
    push("ld_t4", 32'h00800000, 0, 0, CO | ZI, 3, 1);
    push("ld_t5", 32'h00800000, 0, 0, ZLO | MARI, 0, 1);
    push("ld_t6", 32'h00800000, 0, 0, RD | MDRI, 0, 1);
    push("ld_t7", 32'h00800000, 0, 0, MDRO | GRA | REN, 0, 1);
    fetch("st", 32'h10000000, 0);
    push("st_t3", 32'h10000000, 0, 0, GRB | RSEL | BA | YI, 0, 1);
    push("st_t4", 32'h10000000, 0, 0, CO | ZI, 3, 1);
    push("st_t5", 32'h10000000, 0, 0, ZLO | MARI, 0, 1);
    push("st_t6", 32'h10000000, 0, 0, GRA | RSEL | MDRI, 0, 1);
    push("st_t7", 32'h10000000, 0, 0, WR, 0, 1);
    fetch("ldi", 32'h08000000, 0);
    push("ldi_t3", 32'h08000000, 0, 0, GRB | RSEL | BA | YI, 0, 1);
    push("ldi_t4", 32'h08000000, 0, 0, CO | ZI, 3, 1);
    push("ldi_t5", 32'h08000000, 0, 0, ZLO | GRA | REN, 0, 1);
    fetch("ori", 32'h68000000, 0);
    push("ori_t3", 32'h68000000, 0, 0, GRB | RSEL | YI, 0, 1);
    push("ori_t4", 32'h68000000, 0, 0, CO | ZI, 13, 1);
    push("ori_t5", 32'h68000000, 0, 0, ZLO | GRA | REN, 0, 1);
    fetch("br0", 32'h90000000, 0);
    push("br0_t3", 32'h90000000, 0, 0, GRA | RSEL | CONI, 0, 1);
    push("br0_t4", 32'h90000000, 0, 0, PCO | YI, 0, 1);
    push("br0_t5", 32'h90000000, 0, 0, CO | ZI, 3, 1);
    push("br0_t6", 32'h90000000, 0, 0, ZLO, 0, 1);
    fetch("br1", 32'h90000000, 1);
    push("br1_t3", 32'h90000000, 1, 0, GRA | RSEL | CONI, 0, 1);
    push("br1_t4", 32'h90000000, 1, 0, PCO | YI, 0, 1);
    push("br1_t5", 32'h90000000, 1, 0, CO | ZI, 3, 1);
    push("br1_t6", 32'h90000000, 1, 0, ZLO | PCI, 0, 1);
    fetch("nop", 32'hD0000000, 0);
    push("nop_t3", 32'hD0000000, 0, 0, 0, 0, 1);
    fetch("undef", 32'hF8000000, 0);
    push("undef_t3", 32'hF8000000, 0, 0, 0, 0, 1);
    fetch("addstop", 32'h18918000, 0);
    push("addstop_t3", 32'h18918000, 0, 0, GRB | RSEL | YI, 0, 1);
    push("addstop_t4", 32'h18918000, 0, 1, GRC | RSEL | ZI, 3, 1);
    push("addstop_t5", 32'h18918000, 0, 1, ZLO | GRA | REN, 0, 1);
    push("stop_halt", 32'h18918000, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1 check("reset_state", 0, 0, 0);
    reset = 0;
    foreach (vq[k]) step(vq[k].nm, vq[k].ir, vq[k].con, vq[k].stp, vq[k].b, vq[k].a, vq[k].r);
    step("stop_halt_hold", 32'h18918000, 0, 0, 0, 0, 0);

    pulse_reset("rst_from_stop");
    step("halt_t0", 32'hD8000000, 0, 0, F0, 0, 1);
    step("halt_t1", 32'hD8000000, 0, 0, F1, 0, 1);
    step("halt_t2", 32'hD8000000, 0, 0, F2, 0, 1);
    step("halt_t3", 32'hD8000000, 0, 0, 0, 0, 1);
    for (int n = 0; n < 20; n++) step("halt_hold", 32'h18918000, 0, 0, 0, 0, 0);
    pulse_reset("rst_from_halt");
    step("recover_t0", 32'h10000000, 0, 0, F0, 0, 1);

    step("strst_t1", 32'h10000000, 0, 0, F1, 0, 1);
    step("strst_t2", 32'h10000000, 0, 0, F2, 0, 1);
    step("strst_t3", 32'h10000000, 0, 0, GRB | RSEL | BA | YI, 0, 1);
    step("strst_t4", 32'h10000000, 0, 0, CO | ZI, 3, 1);
    step("strst_t5", 32'h10000000, 0, 0, ZLO | MARI, 0, 1);
    step("strst_t6", 32'h10000000, 0, 0, GRA | RSEL | MDRI, 0, 1);
    win = 1;
    pulse_reset("rst_in_st_t6");
    step("strst_restart_t0", 32'h10000000, 0, 0, F0, 0, 1);
    step("strst_restart_t1", 32'h10000000, 0, 0, F1, 0, 1);
    win = 0;
    checks++;
    if (write_seen !== 1'b0) begin
      fails++;
      $display("FAIL st_write_after_reset: got write_seen=%b, want 0", write_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; port names are clk and reset.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  async active-high; forces S_RESET.
REQ-004 stop  in  1  halt request; sampled only when leaving the final step of an instruction.
REQ-005 ir  in  32  instruction register contents; opcode = ir[31:27].
REQ-006 con_ff  in  1  branch-condition flag; sampled in step T6 of a branch.
REQ-007 gra, grb, grc, r_enable, r_select, ba_out  out  1 each  register select/encode controls.
REQ-008 pc_out, mdr_out, z_low_out, c_out  out  1 each  bus-driver enables.
REQ-009 pc_in, ir_in, mar_in, mdr_in, y_in, z_in, con_in  out  1 each  register load enables.
REQ-010 inc_pc, read, write  out  1 each  PC-increment and memory strobes.
REQ-011 alu_op  out  5  ALU operation code.
REQ-012 run  out  1  high while executing; low in S_RESET and S_HALT.

Function
REQ-013 The block SHALL be a Moore FSM; every output is decoded from the registered state and the latched opcode, and is 0 unless listed for that step.
REQ-014 Fetch SHALL take 3 cycles: T0 pc_out, mar_in, inc_pc, z_in; T1 z_low_out, pc_in, read, mdr_in; T2 mdr_out, ir_in.
REQ-015 Opcode SHALL be latched from ir at the T2->T3 edge and held until the next T2.
REQ-016 R-type (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010): T3 grb, r_select, y_in; T4 grc, r_select, alu_op=opcode, z_in; T5 z_low_out, gra, r_enable; then T0.
REQ-017 Immediate (addi 01011, andi 01100, ori 01101): T3 grb, r_select, y_in; T4 c_out, alu_op=opcode, z_in; T5 z_low_out, gra, r_enable; then T0.
REQ-018 ldi 00001: T3 grb, r_select, ba_out, y_in; T4 c_out, alu_op=ADD, z_in; T5 z_low_out, gra, r_enable; then T0.
REQ-019 ld 00000: T3-T4 as ldi; T5 z_low_out, mar_in; T6 read, mdr_in; T7 mdr_out, gra, r_enable; then T0.
REQ-020 st 00010: T3-T5 as ld; T6 gra, r_select, mdr_in; T7 write; then T0.
REQ-021 br 10010: T3 gra, r_select, con_in; T4 pc_out, y_in; T5 c_out, alu_op=ADD, z_in; T6 z_low_out, plus pc_in only if con_ff=1; then T0.
REQ-022 nop 11010 and any unlisted opcode SHALL go T3->T0 with all step outputs 0.
REQ-023 halt 11011 SHALL go T3->S_HALT; S_HALT holds, all outputs 0, run=0, until reset.
REQ-024 If stop=1 on the edge leaving an instruction's final step, next state SHALL be S_HALT instead of T0; stop has no effect mid-instruction.
REQ-025 read/write SHALL each be high for exactly one cycle per memory access.
REQ-026 ba_out SHALL only assert together with r_select.

Reset
REQ-027 Asserting reset SHALL immediately force S_RESET, all outputs 0, run=0, latched opcode 00000, regardless of current step.
REQ-028 The first rising clk after reset deasserts SHALL move S_RESET->T0 with run=1.

Structure
REQ-029 Opcode constants, ALU_ADD (=00011) and the state enumeration (S_RESET, T0-T7, S_HALT) SHALL live in shared package cpu_ctrl_pkg.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification
REQ-031 Reset release, ir=add r1,r2,r3 (0x18918000) -> T0..T5 in 6 cycles, r_enable+gra high in T5 only, then T0.
REQ-032 ld (opcode 00000) -> read high exactly in T1 and T6, gra+r_enable in T7, 8 cycles total.
REQ-033 br with con_ff=0 then con_ff=1 -> pc_in absent resp. present in T6.
REQ-034 halt (0xD8000000) -> S_HALT after T3, run=0 held 20 cycles; reset recovers to T0.
REQ-035 reset pulsed during T6 of st -> write never asserts, outputs 0 same cycle, restart at T0.
REQ-036 stop=1 raised at T4 of add -> instruction completes, then S_HALT.
